// File: rtl/sm_addsub_acc.sv
// ---------------------------------------------------------------------------
// sm_addsub_acc
//
// Multi-cycle sign-magnitude adder/subtractor with a running accumulator,
// used to reduce neuron partial sums in the DNN datapath. Operands are
// converted to WIDTH+1-bit two's complement, added, then converted back to
// sign-magnitude. The WIDTH+1-bit intermediate cannot overflow because its
// range is +/-2*MAXMAG.
//
// Pipeline: IDLE -> CONV -> ADD -> NORM -> OUT -> IDLE, one cycle per state
// except OUT, which waits for out_ready. With the accepting edge counted as
// the first, out_valid is high after the 4th rising edge. With out_ready held
// high, a new operation is accepted every 5 cycles.
//
// Configuration macro:
//   SM_ADD_SAT_EN  defined   : an overflowing result saturates to {sign, MAXMAG}
//                  undefined : an overflowing magnitude wraps modulo 2^(WIDTH-1)
//   ovf is set on overflow in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   in_valid   in   operand bundle valid
//   in_ready   out  high only in IDLE (and low while rst is asserted)
//   a, b       in   sign-magnitude operands, WIDTH bits
//   op_sub     in   0: A+B, 1: A-B
//   acc_en     in   1: use the accumulator in place of a
//   out_valid  out  result valid (state OUT)
//   out_ready  in   downstream accepts the result
//   sum        out  sign-magnitude result, held until the next NORM
//   ovf        out  result magnitude exceeded MAXMAG
// ---------------------------------------------------------------------------
module sm_addsub_acc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    localparam logic [WIDTH-2:0] MAXMAG = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_ADD,
        S_NORM,
        S_OUT
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             op_sub_q, op_sub_d;
    logic             acc_en_q, acc_en_d;
    logic [WIDTH:0]   opa_q,    opa_d;
    logic [WIDTH:0]   opb_q,    opb_d;
    logic [WIDTH:0]   res_q,    res_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             ovf_q,    ovf_d;
    logic [WIDTH-1:0] acc_q,    acc_d;

    // Sign-magnitude to WIDTH+1-bit two's complement. Negating a zero
    // magnitude yields zero, so negative zero needs no special case.
    function automatic logic [WIDTH:0] sm_to_tc(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] mag_ext;
        mag_ext = {2'b00, v[WIDTH-2:0]};
        return v[WIDTH-1] ? -mag_ext : mag_ext;
    endfunction

    // Normalisation of the two's-complement sum back to sign-magnitude.
    logic             res_neg;
    logic [WIDTH:0]   res_abs;
    logic             norm_ovf;
    logic [WIDTH-2:0] norm_mag;
    logic [WIDTH-1:0] norm_sum;

    always_comb begin
        res_neg  = res_q[WIDTH];
        res_abs  = res_neg ? -res_q : res_q;
        norm_ovf = (res_abs > {2'b00, MAXMAG});
`ifdef SM_ADD_SAT_EN
        norm_mag = norm_ovf ? MAXMAG : res_abs[WIDTH-2:0];
`else
        norm_mag = res_abs[WIDTH-2:0];
`endif
        // A zero magnitude (including one produced by wrapping) is always +0.
        norm_sum = {res_neg && (norm_mag != '0), norm_mag};
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_sub_d = op_sub_q;
        acc_en_d = acc_en_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    op_sub_d = op_sub;
                    acc_en_d = acc_en;
                    state_d  = S_CONV;
                end
            end
            S_CONV: begin
                opa_d   = sm_to_tc(acc_en_q ? acc_q : a_q);
                opb_d   = op_sub_q ? -sm_to_tc(b_q) : sm_to_tc(b_q);
                state_d = S_ADD;
            end
            S_ADD: begin
                res_d   = opa_q + opb_q;
                state_d = S_NORM;
            end
            S_NORM: begin
                // Result, flag and accumulator move together; every operation
                // reloads the accumulator, so acc_en=0 starts a new chain.
                sum_d   = norm_sum;
                ovf_d   = norm_ovf;
                acc_d   = norm_sum;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_sub_q <= 1'b0;
            acc_en_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_sub_q <= op_sub_d;
            acc_en_q <= acc_en_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
        end
    end

    // in_ready is gated by rst so it reads 0 for the whole reset interval.
    assign in_ready  = rst && (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign sum       = sum_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sm_addsub_acc.sv
// ---------------------------------------------------------------------------
// tb_sm_addsub_acc
//
// Self-checking bench for sm_addsub_acc at WIDTH=8 (MAXMAG=127). Expected
// results come from an integer reference model, are queued when an operation
// is driven and are popped when the DUT raises out_valid. Honours
// SM_ADD_SAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sm_addsub_acc;

    localparam int W      = 8;
    localparam int MAXMAG = 127;
`ifdef SM_ADD_SAT_EN
    localparam bit SAT = 1'b1;
    localparam logic [W-1:0] OVF_POS_SUM = 8'h7F;
    localparam logic [W-1:0] OVF_NEG_SUM = 8'hFF;
`else
    localparam bit SAT = 1'b0;
    localparam logic [W-1:0] OVF_POS_SUM = 8'h16;
    localparam logic [W-1:0] OVF_NEG_SUM = 8'h96;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_sub;
    logic         acc_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         ovf;

    int           checks   = 0;
    int           failures = 0;
    exp_t         sb[$];
    logic [W-1:0] model_acc;

    sm_addsub_acc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sm2int(input logic [W-1:0] v);
        int m;
        m = int'(v[W-2:0]);
        return v[W-1] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                   input logic op_i, input logic acc_i,
                                   input logic [W-1:0] acc_v);
        int   va, vb, r, mag, m;
        exp_t e;
        va    = acc_i ? sm2int(acc_v) : sm2int(a_i);
        vb    = sm2int(b_i);
        r     = op_i ? va - vb : va + vb;
        mag   = (r < 0) ? -r : r;
        e.ovf = (mag > MAXMAG);
        if (e.ovf) m = SAT ? MAXMAG : (mag % (MAXMAG + 1));
        else       m = mag;
        e.sum = {(r < 0) && (m != 0), m[W-2:0]};
        return e;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Drive one operation, check latency and result, optionally hold
    // out_ready low for `hold` cycles, then complete the handshake.
    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic op_i, input logic acc_i, input int hold,
                          input bit has_lit, input logic [W-1:0] lit,
                          input string tag);
        int   lat;
        exp_t e;
        wait_ready(tag);
        a        = a_i;
        b        = b_i;
        op_sub   = op_i;
        acc_en   = acc_i;
        in_valid = 1'b1;
        out_ready = 1'b0;
        e = model(a_i, b_i, op_i, acc_i, model_acc);
        model_acc = e.sum;
        sb.push_back(e);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, 4);
        e = sb.pop_front();
        check({tag, "_sum"}, sum, e.sum);
        check({tag, "_ovf"}, ovf, e.ovf);
        if (has_lit) check({tag, "_sum_lit"}, sum, lit);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
            check({tag, "_hold_sum"}, sum, e.sum);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_sum_held"}, sum, e.sum);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op_sub    = 1'b0;
        acc_en    = 1'b0;
        model_acc = '0;
        #1;
        check("reset_sum", sum, 0);
        check("reset_ovf", ovf, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);

        run_op(8'h05, 8'h83, 1'b0, 1'b0, 0, 1'b1, 8'h02, "mixed_add");
        run_op(8'h05, 8'h07, 1'b1, 1'b0, 0, 1'b1, 8'h82, "subtract");
        run_op(8'h80, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h00, "neg_zero");
        run_op(8'h85, 8'h05, 1'b0, 1'b0, 0, 1'b1, 8'h00, "cancel_zero");
        run_op(8'h64, 8'h32, 1'b0, 1'b0, 0, 1'b1, OVF_POS_SUM, "ovf_pos");
        check("ovf_pos_flag", ovf, 1);
        run_op(8'hE4, 8'hB2, 1'b0, 1'b0, 0, 1'b1, OVF_NEG_SUM, "ovf_neg");
        check("ovf_neg_flag", ovf, 1);
        run_op(8'h0A, 8'h03, 1'b0, 1'b0, 0, 1'b1, 8'h0D, "acc_op1");
        run_op(8'h00, 8'h85, 1'b0, 1'b1, 6, 1'b1, 8'h08, "acc_op2");

        // Reset while the operation sits in ADD; its result must be dropped.
        wait_ready("mid_reset");
        a        = 8'h07;
        b        = 8'h01;
        op_sub   = 1'b0;
        acc_en   = 1'b1;
        in_valid = 1'b1;
        sb.push_back(model(8'h07, 8'h01, 1'b0, 1'b1, model_acc));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        void'(sb.pop_back());
        model_acc = '0;
        check("midrst_sum", sum, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", in_ready, 1);
        check("midrst_no_output", out_valid, 0);
        run_op(8'h33, 8'h05, 1'b0, 1'b1, 0, 1'b1, 8'h05, "acc_after_reset");

        // Random chain, mixing new chains and accumulation, with backpressure.
        for (int i = 0; i < 12; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 1'b0, '0, "random");
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_addsub_acc.md
Name: sm_addsub_acc

Overview:
- Parametrised multi-cycle sign-magnitude adder/subtractor with optional running accumulation, used for neuron partial-sum reduction in the DNN datapath.
- Operands and result are sign-magnitude: MSB is the sign, the lower WIDTH-1 bits are the magnitude.
- Internally the block converts to two's complement, adds, then converts back.
- Valid/ready handshakes on input and output allow back-to-back use from a sequencer.

Parameters:
- WIDTH, 32, total operand/result width including the sign bit (minimum 4).
- MAXMAG, 2^(WIDTH-1)-1, derived localparam; largest representable magnitude.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A (sign-magnitude).
- b  input  WIDTH  operand B (sign-magnitude).
- op_sub  input  1  0: A+B, 1: A-B.
- acc_en  input  1  1: use the internal accumulator in place of A.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result (sign-magnitude).
- ovf  output  1  result magnitude exceeded MAXMAG.

Behaviour:
- Reset (asynchronous, rst=0):
  - state=IDLE; sum=0, ovf=0, out_valid=0, in_ready=0 while rst is low.
  - accumulator=0; all internal registers cleared.
  - A reset mid-operation discards the operation; no output is produced for it.
- States: IDLE -> CONV -> ADD -> NORM -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: capture a, b, op_sub, acc_en; go to CONV.
- CONV:
  - Operand A = acc_en ? accumulator : a.
  - Each operand is converted to a WIDTH+1-bit two's complement value. Negative zero (sign=1, magnitude=0) converts to 0.
  - If op_sub=1, negate B.
- ADD: compute the WIDTH+1-bit two's-complement sum. Range ±2·MAXMAG, so there is no internal overflow.
- NORM:
  - Convert back to sign-magnitude.
  - If |result| > MAXMAG: ovf=1 and the magnitude wraps to |result| mod 2^(WIDTH-1), unless SM_ADD_SAT_EN is defined.
  - A zero result is always emitted as +0 (all bits 0). This includes a wrapped magnitude of 0.
  - sum, ovf and the accumulator are updated together at the NORM->OUT edge.
- OUT:
  - out_valid=1; sum and ovf are held stable.
  - Leave to IDLE on the edge where out_ready=1.
  - out_valid deasserts one cycle after the handshake.
- Latency: out_valid rises 4 cycles after the input-acceptance edge.
- Throughput: at most one operation per 5 cycles when out_ready is held high.
- Held outputs: sum and ovf keep their last value after leaving OUT until the next NORM.
- Input capture: in_ready=0 outside IDLE; inputs are ignored in all other states.
- out_ready outside OUT is ignored.
- Accumulator:
  - Loaded with the normalised result on every operation, whether or not acc_en was set.
  - acc_en=0 therefore starts a new accumulation chain.

Optional Feature:
- Macro: SM_ADD_SAT_EN.
- Defined: on overflow, sum = {sign, MAXMAG}, i.e. the result saturates with the correct sign, and ovf=1. The accumulator is loaded with the saturated value.
- Undefined: on overflow, the magnitude wraps modulo 2^(WIDTH-1), the sign is kept, and ovf=1.
- In both builds ovf=0 when no overflow occurs.

Test Plan (WIDTH=8, MAXMAG=127):
- Mixed-sign add: a=0x05 (+5), b=0x83 (-3), op_sub=0, acc_en=0 -> sum=0x02, ovf=0, out_valid exactly 4 cycles after acceptance.
- Subtract: a=0x05 (+5), b=0x07 (+7), op_sub=1 -> sum=0x82 (-2), ovf=0.
- Zero handling: a=0x80 (-0), b=0x00, op_sub=0 -> sum=0x00. Also a=0x85, b=0x05 -> sum=0x00, never 0x80.
- Overflow: a=0x64 (+100), b=0x32 (+50), op_sub=0 -> ovf=1.
  - Without SM_ADD_SAT_EN: sum=0x16.
  - With SM_ADD_SAT_EN: sum=0x7F.
  - Repeat with a=0xE4, b=0xB2: sum=0x96 without the macro, 0xFF with it.
- Accumulate and backpressure:
  - Op1: a=0x0A, b=0x03, acc_en=0 -> sum=0x0D.
  - Op2: b=0x85, acc_en=1 -> sum=0x08.
  - Hold out_ready=0 for 6 cycles: out_valid stays 1, sum stable, in_ready=0.
- Reset mid-operation: drop rst in the ADD state -> outputs 0 immediately. After release, in_ready=1 and the next op with acc_en=1 uses accumulator=0.
